// File: rtl/alu_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_add_pkg
//  Description : Shared constants for the pipelined add/subtract unit:
//                operation encodings and NZCV flag bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_add_pkg;

    // Operation encodings on in_op
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    // Bit positions inside a 4-bit NZCV vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : alu_add_pkg
`default_nettype wire

// File: rtl/alu_add_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : alu_add_chunk
//  Description : One CHUNK-wide ripple adder slice. Besides the carry out it
//                reports the carry into its own MSB, which the top slice uses
//                to derive signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_add_chunk
    import alu_add_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum   = w_total[CHUNK-1:0];
    assign o_cout  = w_total[CHUNK];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    assign o_cmsb  = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ o_sum[CHUNK-1];

endmodule : alu_add_chunk
`default_nettype wire

// File: rtl/alu_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_add_pipe
//  Description : Pipelined ADD/SUB/ADC/SBC unit. The carry chain is cut into
//                WIDTH/CHUNK slices, one per register stage; the last stage
//                register doubles as the output register. Holds the NZCV
//                register, updated when an S=1 op retires. ADC/SBC offers are
//                held off while any S=1 op is in flight (no flag forwarding).
//                Optional macro ALU_ADD_SAT_EN adds in_sat (per-op signed
//                saturation on overflow).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_add_pipe
    import alu_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_s,
`ifdef ALU_ADD_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags
);

    localparam int c_stages = WIDTH / CHUNK;
    localparam int c_last   = c_stages - 1;

    // Stage registers: index k holds an op whose chunks 0..k are summed.
    logic [WIDTH-1:0] r_a    [c_stages];
    logic [WIDTH-1:0] r_b    [c_stages];
    logic [WIDTH-1:0] r_res  [c_stages];
    logic             r_c    [c_stages];
    logic             r_cmsb [c_stages];
    logic             r_z    [c_stages];
    logic             r_s    [c_stages];
    logic             r_vld  [c_stages];
    logic [3:0]       r_flags;

    // Inputs feeding each stage (issue port for k=0, previous stage otherwise)
    logic [WIDTH-1:0] w_src_a   [c_stages];
    logic [WIDTH-1:0] w_src_b   [c_stages];
    logic [WIDTH-1:0] w_src_res [c_stages];
    logic [WIDTH-1:0] w_res_next[c_stages];
    logic             w_src_c   [c_stages];
    logic             w_src_z   [c_stages];
    logic             w_src_s   [c_stages];
    logic             w_src_vld [c_stages];
    logic [CHUNK-1:0] w_sum     [c_stages];
    logic             w_cout    [c_stages];
    logic             w_cmsb    [c_stages];

`ifdef ALU_ADD_SAT_EN
    logic             r_sat     [c_stages];
    logic             w_src_sat [c_stages];
`endif

    logic             w_stall;
    logic             w_busy_s;
    logic             w_accept;
    logic             w_cin;
    logic [WIDTH-1:0] w_b_eff;

    assign out_valid = r_vld[c_last];
    assign flags     = r_flags;
    assign w_stall   = r_vld[c_last] && !out_ready;
    assign w_accept  = in_valid && in_ready;
    assign in_ready  = !rst && !w_stall &&
                       !(((in_op == OP_ADC) || (in_op == OP_SBC)) && w_busy_s);
    assign w_b_eff   = ((in_op == OP_SUB) || (in_op == OP_SBC)) ? ~in_b : in_b;

    // Any in-flight op that will write flags blocks ADC/SBC issue.
    always_comb begin
        w_busy_s = 1'b0;
        for (int k = 0; k < c_stages; k++) begin
            w_busy_s = w_busy_s | (r_vld[k] & r_s[k]);
        end
    end

    // Carry-in selection; ADC/SBC read the architectural C at issue time.
    always_comb begin
        w_cin = 1'b0;
        case (in_op)
            OP_ADD:  w_cin = 1'b0;
            OP_SUB:  w_cin = 1'b1;
            OP_ADC:  w_cin = r_flags[FLAG_C];
            OP_SBC:  w_cin = r_flags[FLAG_C];
            default: w_cin = 1'b0;
        endcase
    end

    for (genvar k = 0; k < c_stages; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_src_a[k]   = in_a;
            assign w_src_b[k]   = w_b_eff;
            assign w_src_res[k] = '0;
            assign w_src_c[k]   = w_cin;
            assign w_src_z[k]   = 1'b1;
            assign w_src_s[k]   = in_s;
            assign w_src_vld[k] = w_accept;
`ifdef ALU_ADD_SAT_EN
            assign w_src_sat[k] = in_sat;
`endif
        end else begin : g_tail
            assign w_src_a[k]   = r_a[k-1];
            assign w_src_b[k]   = r_b[k-1];
            assign w_src_res[k] = r_res[k-1];
            assign w_src_c[k]   = r_c[k-1];
            assign w_src_z[k]   = r_z[k-1];
            assign w_src_s[k]   = r_s[k-1];
            assign w_src_vld[k] = r_vld[k-1];
`ifdef ALU_ADD_SAT_EN
            assign w_src_sat[k] = r_sat[k-1];
`endif
        end

        alu_add_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .i_a    (w_src_a[k][k*CHUNK +: CHUNK]),
            .i_b    (w_src_b[k][k*CHUNK +: CHUNK]),
            .i_cin  (w_src_c[k]),
            .o_sum  (w_sum[k]),
            .o_cout (w_cout[k]),
            .o_cmsb (w_cmsb[k])
        );

        // Lower chunks arrive already summed; slot this stage's chunk in.
        assign w_res_next[k] = w_src_res[k] | (WIDTH'(w_sum[k]) << (k * CHUNK));

        // Advance one slice per cycle; the whole pipe freezes on output stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld[k]  <= 1'b0;
                r_a[k]    <= '0;
                r_b[k]    <= '0;
                r_res[k]  <= '0;
                r_c[k]    <= 1'b0;
                r_cmsb[k] <= 1'b0;
                r_z[k]    <= 1'b0;
                r_s[k]    <= 1'b0;
`ifdef ALU_ADD_SAT_EN
                r_sat[k]  <= 1'b0;
`endif
            end else if (!w_stall) begin
                r_vld[k]  <= w_src_vld[k];
                r_a[k]    <= w_src_a[k];
                r_b[k]    <= w_src_b[k];
                r_res[k]  <= w_res_next[k];
                r_c[k]    <= w_cout[k];
                r_cmsb[k] <= w_cmsb[k];
                r_z[k]    <= w_src_z[k] & (w_sum[k] == '0);
                r_s[k]    <= w_src_s[k];
`ifdef ALU_ADD_SAT_EN
                r_sat[k]  <= w_src_sat[k];
`endif
            end
        end
    end

    // Per-op NZCV of the result sitting in the output stage.
    always_comb begin
        out_flags         = 4'b0000;
        out_flags[FLAG_N] = r_res[c_last][WIDTH-1];
        out_flags[FLAG_Z] = r_z[c_last];
        out_flags[FLAG_C] = r_c[c_last];
        out_flags[FLAG_V] = r_cmsb[c_last] ^ r_c[c_last];
    end

`ifdef ALU_ADD_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow the wrapped sign is inverted: negative wrap means a true
    // positive sum, so clamp to the max positive value, and vice versa.
    always_comb begin
        out_result = r_res[c_last];
        if (r_sat[c_last] && out_flags[FLAG_V]) begin
            out_result = r_res[c_last][WIDTH-1] ? c_sat_pos : c_sat_neg;
        end
    end
`else
    assign out_result = r_res[c_last];
`endif

    // Architectural flags change only on a retire handshake of an S=1 op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else if (r_vld[c_last] && out_ready && r_s[c_last]) begin
            r_flags <= out_flags;
        end
    end

endmodule : alu_add_pipe
`default_nettype wire
